// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and address constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
  localparam logic [31:0] PC_INCR              = 32'd4;

endpackage

// File: rtl/next_pc_select.sv
// Priority mux choosing the address loaded into the program counter.
module next_pc_select
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic        boot,
  input  logic        exc_pend,
  input  logic        eret_pend,
  input  logic        pend_valid,
  input  logic [31:0] epc,
  input  logic [31:0] pend_target,
  input  logic [31:0] pc_address,
  output logic [31:0] next_address
);

  // Exception beats eret, eret beats a pending redirect; the add wraps modulo 2^32.
  always_comb begin
    if (boot)
      next_address = RESET_VECTOR;
    else if (exc_pend)
      next_address = EXC_VECTOR;
    else if (eret_pend)
      next_address = epc;
    else if (pend_valid)
      next_address = pend_target;
    else
      next_address = pc_address + PC_INCR;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Decides when and where the program counter loads, and drives the imem fetch
// handshake while honouring the single branch delay slot.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        exception,
  input  logic        eret,
  output logic        pc_write,
  output logic [31:0] next_address,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic        instr_valid,
  output logic [31:0] epc
);

  seq_state_t  state;
  seq_state_t  next_state;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        exc_pend;
  logic        eret_pend;
  logic [31:0] saved_epc;
  logic        fetch_go;
  logic        accept;
  logic        redirect;
  logic        consume;
  logic [31:0] mux_address;

  next_pc_select #(
    .RESET_VECTOR (RESET_VECTOR),
    .EXC_VECTOR   (EXC_VECTOR)
  ) u_next_pc_select (
    .boot         (state == BOOT),
    .exc_pend     (exc_pend),
    .eret_pend    (eret_pend),
    .pend_valid   (pend_valid),
    .epc          (saved_epc),
    .pend_target  (pend_target),
    .pc_address   (pc_address),
    .next_address (mux_address)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= BOOT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT:    next_state = FETCH;
      FETCH:   if (fetch_go && !imem_ready) next_state = WAIT;
      WAIT:    if (imem_ready) next_state = FETCH;
      default: next_state = BOOT;
    endcase
  end

  // A pending exception or eret in FETCH redirects the PC without issuing a fetch.
  always_comb begin
    fetch_go = 1'b0;
    accept   = 1'b0;
    redirect = 1'b0;
    case (state)
      FETCH: begin
        redirect = exc_pend || eret_pend;
        fetch_go = !stall && !redirect;
        accept   = fetch_go && imem_ready;
      end
      WAIT: begin
        fetch_go = 1'b1;
        accept   = imem_ready;
      end
      default: ;
    endcase
    pc_write     = reset && ((state == BOOT) || accept || redirect);
    instr_valid  = reset && accept && !exc_pend;
    fetch_req    = reset && fetch_go;
    fetch_addr   = reset ? pc_address : '0;
    next_address = reset ? mux_address : RESET_VECTOR;
    epc          = reset ? saved_epc : '0;
  end

  assign consume = accept || redirect;

  // New events win over clearing; an exception drops a simultaneous eret or redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
      exc_pend    <= 1'b0;
      eret_pend   <= 1'b0;
      saved_epc   <= '0;
    end else begin
      if (exception) begin
        exc_pend  <= 1'b1;
        saved_epc <= pc_address;
      end else if (consume && exc_pend) begin
        exc_pend <= 1'b0;
      end

      if (eret && !exception)
        eret_pend <= 1'b1;
      else if (consume && !exc_pend && eret_pend)
        eret_pend <= 1'b0;

      if (!pend_valid && !exception && (branch_taken || jump_valid)) begin
        pend_valid  <= 1'b1;
        pend_target <= branch_taken ? branch_target : jump_target;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a cycle model pushes expected outputs to a
// scoreboard queue, which is popped and compared against the DUT each cycle.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exception;
  logic        eret;
  logic        pc_write;
  logic [31:0] next_address;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        instr_valid;
  logic [31:0] epc;

  pc_sequencer #(
    .RESET_VECTOR (RST_VEC),
    .EXC_VECTOR   (EXC_VEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_address    (pc_address),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .exception     (exception),
    .eret          (eret),
    .pc_write      (pc_write),
    .next_address  (next_address),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .instr_valid   (instr_valid),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_write;
    logic [31:0] next_address;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        instr_valid;
    logic [31:0] epc;
  } exp_t;

  typedef enum int {M_BOOT, M_FETCH, M_WAIT} mstate_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;

  mstate_t     m_state = M_BOOT;
  logic        m_pend = 1'b0;
  logic [31:0] m_target = '0;
  logic        m_exc = 1'b0;
  logic        m_eret = 1'b0;
  logic [31:0] m_epc = '0;
  logic [31:0] m_pc = 32'h1234_5678;

  logic        obs_pc_write;
  logic [31:0] obs_next;
  logic        obs_fetch_req;
  logic [31:0] obs_fetch_addr;
  logic        obs_instr_valid;
  logic [31:0] obs_epc;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare from the scoreboard, then advance the model.
  task automatic applyStimulus(input logic rst, input logic st, input logic rdy,
                               input logic bt, input logic [31:0] btgt,
                               input logic jv, input logic [31:0] jtgt,
                               input logic exc, input logic er);
    exp_t e;
    exp_t got;
    logic acc;
    logic consume;
    reset = rst; stall = st; imem_ready = rdy;
    branch_taken = bt; branch_target = btgt;
    jump_valid = jv; jump_target = jtgt;
    exception = exc; eret = er;
    pc_address = m_pc;

    e = '{pc_write: 1'b0, next_address: RST_VEC, fetch_req: 1'b0,
          fetch_addr: '0, instr_valid: 1'b0, epc: '0};
    acc = 1'b0;
    if (rst) begin
      e.fetch_addr = m_pc;
      e.epc = m_epc;
      e.next_address = m_pc + 32'd4;
      if (m_state == M_BOOT) begin
        e.pc_write = 1'b1; e.next_address = RST_VEC;
      end else if (m_state == M_FETCH && m_exc) begin
        e.pc_write = 1'b1; e.next_address = EXC_VEC;
      end else if (m_state == M_FETCH && m_eret) begin
        e.pc_write = 1'b1; e.next_address = m_epc;
      end else begin
        e.fetch_req = (m_state == M_WAIT) || !st;
        acc = e.fetch_req && rdy;
      end
      if (acc) begin
        e.pc_write = 1'b1;
        e.instr_valid = !m_exc;
        if (m_exc) e.next_address = EXC_VEC;
        else if (m_eret) e.next_address = m_epc;
        else if (m_pend) e.next_address = m_target;
      end
    end
    sb.push_back(e);

    #2;
    obs_pc_write = pc_write; obs_next = next_address; obs_fetch_req = fetch_req;
    obs_fetch_addr = fetch_addr; obs_instr_valid = instr_valid; obs_epc = epc;
    got = sb.pop_front();
    checkOutput("pc_write", {31'b0, obs_pc_write}, {31'b0, got.pc_write});
    checkOutput("fetch_req", {31'b0, obs_fetch_req}, {31'b0, got.fetch_req});
    checkOutput("instr_valid", {31'b0, obs_instr_valid}, {31'b0, got.instr_valid});
    checkOutput("fetch_addr", obs_fetch_addr, got.fetch_addr);
    checkOutput("epc", obs_epc, got.epc);
    if (got.pc_write || !rst) checkOutput("next_address", obs_next, got.next_address);

    @(posedge clk);
    if (!rst) begin
      m_state = M_BOOT; m_pend = 1'b0; m_target = '0;
      m_exc = 1'b0; m_eret = 1'b0; m_epc = '0;
    end else begin
      consume = got.pc_write && (m_state != M_BOOT);
      if (er && !exc) m_eret = 1'b1;
      else if (consume && !m_exc && m_eret) m_eret = 1'b0;
      if (exc) begin m_exc = 1'b1; m_epc = m_pc; end
      else if (consume) m_exc = 1'b0;
      if (!m_pend && !exc && (bt || jv)) begin
        m_pend = 1'b1; m_target = bt ? btgt : jtgt;
      end else if (consume) m_pend = 1'b0;
      case (m_state)
        M_BOOT:  m_state = M_FETCH;
        M_FETCH: if (got.fetch_req && !rdy) m_state = M_WAIT;
        default: if (rdy) m_state = M_FETCH;
      endcase
      if (got.pc_write) m_pc = got.next_address;
    end
    @(negedge clk);
  endtask

  task automatic plainCycle(input logic st, input logic rdy);
    applyStimulus(1'b1, st, rdy, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; pc_address = m_pc;
    branch_taken = 1'b0; branch_target = '0; jump_valid = 1'b0; jump_target = '0;
    exception = 1'b0; eret = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_pc_write", {31'b0, obs_pc_write}, 32'd0);

    plainCycle(1'b0, 1'b1);
    checkOutput("boot_pc_write", {31'b0, obs_pc_write}, 32'd1);
    checkOutput("boot_next", obs_next, 32'h0);
    for (int i = 0; i < 4; i++) begin
      plainCycle(1'b0, 1'b1);
      checkOutput("boot_fetch_addr", obs_fetch_addr, 32'(i * 4));
      checkOutput("boot_instr_valid", {31'b0, obs_instr_valid}, 32'd1);
    end

    plainCycle(1'b0, 1'b0);
    checkOutput("wait_addr0", obs_fetch_addr, 32'h10);
    plainCycle(1'b1, 1'b0);
    checkOutput("wait_req_stall", {31'b0, obs_fetch_req}, 32'd1);
    checkOutput("wait_addr1", obs_fetch_addr, 32'h10);
    plainCycle(1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("wait_next", obs_next, 32'h14);

    for (int i = 0; i < 3; i++) plainCycle(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("slot_addr", obs_fetch_addr, 32'h20);
    checkOutput("slot_next", obs_next, 32'h100);
    plainCycle(1'b0, 1'b1);
    checkOutput("target_fetch0", obs_fetch_addr, 32'h100);
    plainCycle(1'b0, 1'b1);
    checkOutput("target_fetch1", obs_fetch_addr, 32'h104);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h40, 1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("exc_epc", obs_epc, 32'h40);
    checkOutput("exc_instr_valid", {31'b0, obs_instr_valid}, 32'd0);
    checkOutput("exc_next", obs_next, 32'h8000_0180);
    plainCycle(1'b0, 1'b1);
    checkOutput("exc_branch_dropped", obs_next, 32'h8000_0184);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("eret_idle", {31'b0, obs_pc_write}, 32'd0);
    plainCycle(1'b0, 1'b1);
    checkOutput("eret_pc_write", {31'b0, obs_pc_write}, 32'd1);
    checkOutput("eret_next", obs_next, 32'h40);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("exc_fetch_next", obs_next, 32'h8000_0180);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    plainCycle(1'b0, 1'b1);
    checkOutput("eret_wait_next", obs_next, 32'h40);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("branch_wins", obs_next, 32'h200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    plainCycle(1'b0, 1'b1);
    checkOutput("wrap_addr", obs_fetch_addr, 32'hFFFF_FFFC);
    checkOutput("wrap_next", obs_next, 32'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h700, 1'b0, 1'b0);
    plainCycle(1'b0, 1'b1);
    checkOutput("first_redirect", obs_next, 32'h600);
    plainCycle(1'b0, 1'b1);
    checkOutput("second_ignored", obs_next, 32'h604);

    plainCycle(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("wait_reset_pc_write", {31'b0, obs_pc_write}, 32'd0);
    plainCycle(1'b0, 1'b1);
    checkOutput("reboot_next", obs_next, 32'h0);
    plainCycle(1'b0, 1'b1);

    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
